// File: rtl/seq_count_3b_dir_decode.sv
// seq_count_3b_dir_decode
// Receive-side checker for a 3-bit binary up/down counter. It infers the count
// direction from successive samples, flags illegal steps and tracks the run
// length of same-direction steps. Lock is dropped after MISS_MAX consecutive
// illegal steps and reacquired on the next legal step.
//
// Optional feature: define SEQ_COUNT_DIR_HOLD_EN to treat a repeated sample
// (delta == 0) as a legal "hold" step. Default build: delta == 0 is illegal.
//
// Parameters:
//   MISS_MAX  consecutive illegal steps in LOCK before falling back (1..7)
//   RUN_W     width of run; the count saturates at 2^RUN_W-1
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-low reset
//   in_val   a new counter sample is present this cycle
//   in       3-bit counter sample
//   dir      inferred direction: 0 = up, 1 = down
//   dir_val  one-cycle pulse: dir/run updated by a legal step
//   err      one-cycle pulse: illegal step detected
//   locked   checker is in LOCK
//   run      consecutive legal steps in the current direction
module seq_count_3b_dir_decode #(
  parameter int unsigned MISS_MAX = 2,
  parameter int unsigned RUN_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  input  logic [2:0]       in,
  output logic             dir,
  output logic             dir_val,
  output logic             err,
  output logic             locked,
  output logic [RUN_W-1:0] run
);

  typedef enum logic [1:0] {StIdle, StPrime, StLock} state_e;

  localparam logic [2:0]       MissMax = 3'(MISS_MAX);
  localparam logic [RUN_W-1:0] RunMax  = '1;

  state_e           state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic [2:0]       miss_q, miss_d;
  logic             dir_q, dir_d;
  logic             dir_val_q, dir_val_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;
  logic [RUN_W-1:0] run_q, run_d;

  logic [2:0] delta;
  logic [2:0] miss_inc;
  logic       step_up, step_dn, legal, hold;

  // Modulo-8 difference makes 7->0 an up step and 0->7 a down step for free.
  assign delta    = in - prev_q;
  assign step_up  = (delta == 3'd1);
  assign step_dn  = (delta == 3'd7);
  assign legal    = step_up | step_dn;
  assign miss_inc = miss_q + 3'd1;

`ifdef SEQ_COUNT_DIR_HOLD_EN
  assign hold = (delta == 3'd0);
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    miss_d    = miss_q;
    dir_d     = dir_q;
    run_d     = run_q;
    dir_val_d = 1'b0;
    err_d     = 1'b0;

    if (in_val) begin
      prev_d = in;
      unique case (state_q)
        StIdle: begin
          state_d = StPrime;
        end
        StPrime: begin
          if (legal) begin
            dir_d     = step_dn;
            run_d     = RUN_W'(1);
            dir_val_d = 1'b1;
            miss_d    = 3'd0;
            state_d   = StLock;
          end else if (!hold) begin
            err_d = 1'b1;
          end
        end
        StLock: begin
          if (legal) begin
            dir_val_d = 1'b1;
            dir_d     = step_dn;
            miss_d    = 3'd0;
            if (step_dn == dir_q) begin
              run_d = (run_q == RunMax) ? run_q : run_q + RUN_W'(1);
            end else begin
              run_d = RUN_W'(1);
            end
          end else if (hold) begin
            miss_d = 3'd0;
          end else begin
            err_d = 1'b1;
            if (miss_inc == MissMax) begin
              state_d = StPrime;
              run_d   = '0;
              miss_d  = 3'd0;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

    locked_d = (state_d == StLock);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      prev_q    <= 3'd0;
      miss_q    <= 3'd0;
      dir_q     <= 1'b0;
      dir_val_q <= 1'b0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
      run_q     <= '0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      miss_q    <= miss_d;
      dir_q     <= dir_d;
      dir_val_q <= dir_val_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
      run_q     <= run_d;
    end
  end

  assign dir     = dir_q;
  assign dir_val = dir_val_q;
  assign err     = err_q;
  assign locked  = locked_q;
  assign run     = run_q;

endmodule
